// File: rtl/dmem_responder.sv
// Slow data-memory responder: one request at a time, response after LATENCY cycles.
// Define DMEM_MISALIGN_ERR_EN to flag accesses with req_addr[1:0] != 0 as errors.
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   offset;
  logic [AW-1:0] widx;
  logic          in_range, misal, err_req, accept;
  logic [31:0]   acc_rdata, pend_rdata;
  logic          pend_err;

  assign offset   = req_addr - BASE_ADDR;
  assign in_range = {1'b0, offset} < (33'(DEPTH) << 2);
  assign widx     = offset[AW+1:2];
`ifdef DMEM_MISALIGN_ERR_EN
  assign misal    = |req_addr[1:0];
`else
  assign misal    = 1'b0;
`endif
  assign err_req   = !in_range || misal;
  assign accept    = req_valid && req_ready;
  assign acc_rdata = (!req_we && !err_req) ? mem[widx] : 32'h0;

  // RAM is deliberately outside the reset domain; stores commit on the accept edge
  always_ff @(posedge clk) begin
    if (accept && req_we && !err_req)
      for (int b = 0; b < 4; b++)
        if (req_be[b]) mem[widx][8*b +: 8] <= req_wdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      req_ready <= (next_state == IDLE);
      rsp_valid <= (next_state == RESP);
      if (accept) begin
        cnt        <= CNT_INIT;
        pend_rdata <= acc_rdata;
        pend_err   <= err_req;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Response fields stay 0 until RESP; with LATENCY==1 they come straight from the accept
      if (next_state != RESP) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end else if (state != RESP) begin
        rsp_rdata <= (state == IDLE) ? acc_rdata : pend_rdata;
        rsp_err   <= (state == IDLE) ? err_req   : pend_err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_we = 0, rsp_valid, rsp_ready = 0, rsp_err;
  logic [3:0]  req_be = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;

  logic        req_valid_1 = 0, req_ready_1, req_we_1 = 0, rsp_valid_1, rsp_ready_1 = 0, rsp_err_1;
  logic [3:0]  req_be_1 = 0;
  logic [31:0] req_addr_1 = 0, req_wdata_1 = 0, rsp_rdata_1;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
    .req_be(req_be_1), .req_addr(req_addr_1), .req_wdata(req_wdata_1), .rsp_valid(rsp_valid_1),
    .rsp_ready(rsp_ready_1), .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1));

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One full transaction on the LATENCY=2 instance; call and return at a negedge.
  task automatic xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1 req_valid = 0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (lat == 1) check("ready_drop", 32'(req_ready), 32'd0);
      if (rsp_valid) break;
    end
    rdata = rsp_rdata; err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_we = 0; req_addr = 32'h44;
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rdata);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
    @(negedge clk);
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_rdata", rsp_rdata, 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, last_acc, n_acc;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // store then load back
    xfer(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    check("st_lat", 32'(lat), 32'd2); check("st_err", 32'(er), 32'd0); check("st_rdata", rd, 32'd0);
    xfer(0, 4'h0, 32'h10, 32'h0, 0, rd, er, lat);
    check("ld_lat", 32'(lat), 32'd2); check("ld_rdata", rd, 32'hDEADBEEF); check("ld_err", 32'(er), 32'd0);

    // byte enables
    xfer(1, 4'hF, 32'h20, 32'h11223344, 0, rd, er, lat);
    xfer(1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, rd, er, lat);
    xfer(0, 4'h0, 32'h20, 32'h0, 0, rd, er, lat);
    check("be_merge", rd, 32'h11BB33DD);

    // backpressure with a competing request held
    xfer(0, 4'h0, 32'h10, 32'h0, 5, rd, er, lat);
    check("bp_rdata", rd, 32'hDEADBEEF);

    // out of range: no aliasing onto word 0
    xfer(1, 4'hF, 32'h0, 32'h0, 0, rd, er, lat);
    xfer(0, 4'h0, 32'h1000, 32'h0, 0, rd, er, lat);
    check("oor_ld_err", 32'(er), 32'd1); check("oor_ld_rdata", rd, 32'd0); check("oor_lat", 32'(lat), 32'd2);
    xfer(1, 4'hF, 32'h1000, 32'hFFFFFFFF, 0, rd, er, lat);
    check("oor_st_err", 32'(er), 32'd1);
    xfer(0, 4'h0, 32'h0, 32'h0, 0, rd, er, lat);
    check("word0_intact", rd, 32'h0); check("word0_err", 32'(er), 32'd0);

    // misaligned store to 0x22
    xfer(1, 4'hF, 32'h22, 32'h55667788, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    check("mis_st_err", 32'(er), 32'd1);
    xfer(0, 4'h0, 32'h20, 32'h0, 0, rd, er, lat);
    check("mis_word", rd, 32'h11BB33DD);
`else
    check("mis_st_err", 32'(er), 32'd0);
    xfer(0, 4'h0, 32'h20, 32'h0, 0, rd, er, lat);
    check("mis_word", rd, 32'h55667788);
`endif

    // reset during WAIT of a store
    req_valid = 1; req_we = 1; req_be = 4'hF; req_addr = 32'h30; req_wdata = 32'h0BADF00D;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    rst = 0;
    #1;
    check("rstmid_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rstmid_valid2", 32'(rsp_valid), 32'd0);
    rst = 1;
    @(negedge clk);
    check("rstrel_ready", 32'(req_ready), 32'd1);
    check("rstrel_valid", 32'(rsp_valid), 32'd0);
    xfer(0, 4'h0, 32'h30, 32'h0, 0, rd, er, lat);
    check("rst_store_kept", rd, 32'h0BADF00D);

    // LATENCY=1 instance
    check("l1_ready", 32'(req_ready_1), 32'd1);
    req_valid_1 = 1; req_we_1 = 1; req_be_1 = 4'hF; req_addr_1 = 32'h40; req_wdata_1 = 32'hCAFEF00D;
    @(posedge clk); #1 req_valid_1 = 0;
    @(negedge clk);
    check("l1_valid_t1", 32'(rsp_valid_1), 32'd1);
    check("l1_st_err", 32'(rsp_err_1), 32'd0);
    rsp_ready_1 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    req_valid_1 = 1; req_we_1 = 0; req_addr_1 = 32'h40;
    last_acc = -1; n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_ready_1) begin
        if (last_acc >= 0) check("l1_gap", 32'(c - last_acc), 32'd2);
        last_acc = c; n_acc++;
      end
      if (rsp_valid_1) check("l1_rdata", rsp_rdata_1, 32'hCAFEF00D);
      @(negedge clk);
    end
    req_valid_1 = 0; rsp_ready_1 = 0;
    check("l1_n_acc", 32'(n_acc), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
